// File: rtl/dcache_ctrl_if.sv
// ============================================================================
// dcache_ctrl_if : CPU data-port and line-memory handshake bundle
// Rev 1.0
// ============================================================================
`default_nettype none

interface dcache_ctrl_if #(
  parameter int WORD_SIZE = 16
);
  logic                 cpu_read;
  logic                 cpu_write;
  logic [15:0]          cpu_address;
  logic [WORD_SIZE-1:0] cpu_write_data;
  logic [WORD_SIZE-1:0] cpu_read_data;
  logic                 cpu_done;

  logic                 mem_readM;
  logic                 mem_writeM;
  logic [15:0]          mem_address;
  logic                 mem_readyM;
  logic                 mem_input_readyM;
  logic                 mem_doneM;

  modport slave (
    input  cpu_read, cpu_write, cpu_address, cpu_write_data,
    output cpu_read_data, cpu_done,
    output mem_readM, mem_writeM, mem_address,
    input  mem_readyM, mem_input_readyM, mem_doneM
  );

  modport master (
    output cpu_read, cpu_write, cpu_address, cpu_write_data,
    input  cpu_read_data, cpu_done,
    input  mem_readM, mem_writeM, mem_address,
    output mem_readyM, mem_input_readyM, mem_doneM
  );
endinterface

`default_nettype wire

// File: rtl/dcache_ctrl.sv
// ============================================================================
// dcache_ctrl : direct-mapped, write-through, write-allocate data cache
// Rev 1.0
// ============================================================================
`default_nettype none

module dcache_ctrl #(
  parameter int LINES     = 4,
  parameter int WORD_SIZE = 16
) (
  input  logic                   clk,
  input  logic                   reset_n,
  dcache_ctrl_if.slave           bus,
  inout  wire  [4*WORD_SIZE-1:0] mem_data,
  output logic [15:0]            hit_count,
  output logic [15:0]            miss_count
);
  localparam int INDEX_BITS = $clog2(LINES);
  localparam int TAG_BITS   = 16 - INDEX_BITS - 2;
  localparam int LINE_BITS  = 4 * WORD_SIZE;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FILL  = 2'd1,
    S_WRITE = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_state_next;
  logic [LINES-1:0]      r_valid;
  logic [TAG_BITS-1:0]   r_tag  [LINES];
  logic [LINE_BITS-1:0]  r_data [LINES];
  logic [LINE_BITS-1:0]  r_wbuf;
  logic                  r_mem_read;
  logic                  r_mem_write;
  logic [13:0]           r_line_addr;
  logic [15:0]           r_hits;
  logic [15:0]           r_misses;
  logic                  r_retry;

  logic [1:0]            w_offset;
  logic [INDEX_BITS-1:0] w_index;
  logic [TAG_BITS-1:0]   w_tag;
  logic [INDEX_BITS-1:0] w_fill_index;
  logic [TAG_BITS-1:0]   w_fill_tag;
  logic                  w_wr;
  logic                  w_rd;
  logic                  w_hit;
  logic                  w_read_hit;
  logic                  w_write_hit;
  logic                  w_miss_go;
  logic                  w_fill_done;
  logic                  w_write_done;
  logic [LINE_BITS-1:0]  w_line;
  logic [LINE_BITS-1:0]  w_merged;
  logic [WORD_SIZE-1:0]  w_rdata;

  assign w_offset     = bus.cpu_address[1:0];
  assign w_index      = bus.cpu_address[INDEX_BITS+1:2];
  assign w_tag        = bus.cpu_address[15:INDEX_BITS+2];
  assign w_fill_index = r_line_addr[INDEX_BITS-1:0];
  assign w_fill_tag   = r_line_addr[13:INDEX_BITS];
  assign w_wr         = bus.cpu_write;
  assign w_rd         = bus.cpu_read & ~bus.cpu_write;
  assign w_line       = r_data[w_index];
  assign w_hit        = r_valid[w_index] && (r_tag[w_index] == w_tag);

  assign w_read_hit   = (r_state == S_IDLE) && w_rd && w_hit;
  assign w_write_hit  = (r_state == S_IDLE) && w_wr && w_hit;
  assign w_miss_go    = (r_state == S_IDLE) && (w_rd || w_wr) && !w_hit && bus.mem_readyM;
  assign w_fill_done  = (r_state == S_FILL) && bus.mem_input_readyM;
  assign w_write_done = (r_state == S_WRITE) && bus.mem_doneM;

  always_comb begin
    w_merged = w_line;
    w_rdata  = '0;
    for (int k = 0; k < 4; k++) begin
      if (w_offset == 2'(k)) begin
        w_merged[k*WORD_SIZE +: WORD_SIZE] = bus.cpu_write_data;
        w_rdata                            = w_line[k*WORD_SIZE +: WORD_SIZE];
      end
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_write_hit)    w_state_next = S_WRITE;
        else if (w_miss_go) w_state_next = S_FILL;
      end
      S_FILL:  if (bus.mem_input_readyM) w_state_next = S_IDLE;
      S_WRITE: if (bus.mem_doneM)        w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // r_retry marks the cycle right after a fill, whose hit must not be counted
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_valid     <= '0;
      r_mem_read  <= 1'b0;
      r_mem_write <= 1'b0;
      r_line_addr <= '0;
      r_hits      <= '0;
      r_misses    <= '0;
      r_retry     <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_retry <= w_fill_done;
      if (w_miss_go) begin
        r_mem_read  <= 1'b1;
        r_line_addr <= bus.cpu_address[15:2];
        if (r_misses != 16'hFFFF) r_misses <= r_misses + 16'd1;
      end
      if (w_write_hit) begin
        r_mem_write <= 1'b1;
        r_line_addr <= bus.cpu_address[15:2];
      end
      if ((w_read_hit || w_write_hit) && !r_retry && (r_hits != 16'hFFFF))
        r_hits <= r_hits + 16'd1;
      if (w_fill_done) begin
        r_mem_read            <= 1'b0;
        r_valid[w_fill_index] <= 1'b1;
      end
      if (w_write_done) r_mem_write <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (w_fill_done) begin
      r_data[w_fill_index] <= mem_data;
      r_tag[w_fill_index]  <= w_fill_tag;
    end
    if (w_write_hit) begin
      r_data[w_index] <= w_merged;
      r_wbuf          <= w_merged;
    end
  end

  assign mem_data          = r_mem_write ? r_wbuf : {LINE_BITS{1'bz}};
  assign bus.mem_readM     = r_mem_read;
  assign bus.mem_writeM    = r_mem_write;
  assign bus.mem_address   = {r_line_addr, 2'b00};
  assign bus.cpu_done      = w_read_hit | w_write_done;
  assign bus.cpu_read_data = w_rdata;
  assign hit_count         = r_hits;
  assign miss_count        = r_misses;
endmodule

`default_nettype wire

// File: doc/dcache_ctrl.md
Name: dcache_ctrl

Overview:
- Direct-mapped, write-through, write-allocate data cache controller.
- Sits between the CPU data port (single 16-bit word accesses) and the data port of the line-based memory (4-word/64-bit lines; readM/writeM request with readyM/input_readyM/doneM handshake).
- Acts as initiator on the memory side. Filters read hits and converts CPU writes into full-line write-throughs.

Parameters:
- LINES, 4, number of cache lines (power of two, ≥2); INDEX_BITS = log2(LINES).
- WORD_SIZE, 16, CPU word width; line = 4 words = 4*WORD_SIZE bits.

Ports:
- clk  input  1  clock, all state on posedge.
- reset_n  input  1  asynchronous, active-low reset.
- cpu_read  input  1  read request, held until cpu_done.
- cpu_write  input  1  write request, held until cpu_done; wins over cpu_read if both are high.
- cpu_address  input  16  word address: [1:0] offset, [INDEX_BITS+1:2] index, [15:INDEX_BITS+2] tag.
- cpu_write_data  input  16  write data.
- cpu_read_data  output  16  selected word of the indexed line (combinational).
- cpu_done  output  1  access complete this cycle (combinational).
- mem_readM  output  1  line read request.
- mem_writeM  output  1  line write request.
- mem_address  output  16  line address, always {tag,index,2'b00}.
- mem_data  inout  64  driven with the write line while mem_writeM=1, else high-Z.
- mem_readyM  input  1  memory idle, may accept a request.
- mem_input_readyM  input  1  read line valid on mem_data (one-cycle strobe).
- mem_doneM  input  1  access finished (one-cycle strobe).
- hit_count  output  16  saturating hit counter.
- miss_count  output  16  saturating miss counter.

Behaviour:
- Storage: per line, a valid bit, a tag, and 64 bits of data. hit = valid[index] && tag match.
- Reset (async, any state):
  - All valid bits cleared; state IDLE.
  - mem_readM=0, mem_writeM=0, mem_address=0, mem_data=Z.
  - Counters 0; cpu_done=0.
  - Reset mid-FILL/WRITE abandons the access with no line update. Memory shares reset_n, so both ends restart together.
- States: IDLE, FILL, WRITE.
- IDLE:
  - Read hit: cpu_done=1 in the same cycle; cpu_read_data = line word[offset]; hit_count++. Zero-wait hit.
  - Write hit (takes effect at the posedge): merge cpu_write_data into the line (cache updated now); latch the merged line into the write buffer; mem_writeM<=1; mem_address<=line address; hit_count++; go to WRITE.
  - Any miss with mem_readyM=1 (takes effect at the posedge): mem_readM<=1; mem_address<=line address; miss_count++; go to FILL.
  - Miss with mem_readyM=0: stay in IDLE, no count.
  - No request: outputs idle. cpu_done=0 except for the read-hit case.
- FILL:
  - Hold mem_readM=1 and mem_address stable.
  - On the posedge where mem_input_readyM=1: write mem_data into the line, set tag and valid; mem_readM<=0 (same edge, so memory sees it low before its next sample); go to IDLE.
  - The retried request then hits: reads complete next cycle; write misses proceed as write hits (write-allocate). Do not count a hit on this retry.
- WRITE:
  - Hold mem_writeM=1; drive the write buffer on mem_data.
  - cpu_done = mem_doneM (combinational). On the posedge with mem_doneM=1: mem_writeM<=0, release mem_data, go to IDLE.
- Strobes: input_readyM and doneM are never used as request acceptance. Completion is only recognised in FILL/WRITE respectively.
- Line word packing: word k occupies bits [16k+15:16k].
- Counters saturate at 16'hFFFF (no wrap).
- cpu_done is never 1 in FILL, and is never 1 in WRITE unless mem_doneM=1.

Test Plan:
- Reset, then read 0x0001 with memory words 0–3 = 9023,0001,FFFF,0000 -> FILL with mem_address=0x0000 and one mem_readM request. After the strobe, cpu_done next cycle with data 0x0001; miss_count=1, hit_count=0.
- Then read 0x0002 -> cpu_done same cycle, data 0xFFFF, no memory request; hit_count=1.
- Write 0xABCD to 0x0003 (hit) -> mem_writeM with mem_data=0xABCD_FFFF_0001_9023; cpu_done on mem_doneM. A following read of 0x0003 hits and returns 0xABCD.
- With LINES=4, write 0x1234 to 0x0011 (miss; same index as 0x0001, different tag) -> fill line 0x0010, then write-through of the merged line. A read of 0x0001 then misses again and refills from memory.
- Assert reset_n=0 mid-FILL -> mem_readM drops immediately, valid bits cleared. After release, a read of 0x0000 misses.
- Force hit_count to 0xFFFF via repeated hits -> stays 0xFFFF.
